// File: rtl/bp_stall_hist_counters.sv
// Per-reason stall cycle histogram with saturating live counters and an atomic
// shadow snapshot bank that host software reads through a one-entry response register.
module bp_stall_hist_counters #(
  parameter int num_reasons_p = 32,
  parameter int cnt_width_p   = 32,
  localparam int lg_reasons_lp = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1,
  localparam int addr_width_lp = ((num_reasons_p + 3) > 1) ? $clog2(num_reasons_p + 3) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic                     instret_i,
  input  logic                     stall_v_i,
  input  logic [lg_reasons_lp-1:0] stall_reason_i,
  input  logic                     snap_v_i,
  input  logic                     snap_clear_i,
  output logic                     snap_ready_o,
  input  logic                     rd_v_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic                     rd_ready_o,
  output logic                     rd_data_v_o,
  output logic [cnt_width_p-1:0]   rd_data_o,
  output logic                     rd_err_o,
  input  logic                     rd_yumi_i
);

  localparam int num_cnt_lp   = num_reasons_p + 3;
  localparam int unk_idx_lp   = num_reasons_p;
  localparam int instr_idx_lp = num_reasons_p + 1;
  localparam int cycle_idx_lp = num_reasons_p + 2;

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v,
                                                      input logic inc);
    return (inc && !(&v)) ? v + cnt_width_p'(1) : v;
  endfunction

  logic [cnt_width_p-1:0] live_q   [num_cnt_lp];
  logic [cnt_width_p-1:0] live_d   [num_cnt_lp];
  logic [cnt_width_p-1:0] shadow_q [num_cnt_lp];
  logic [cnt_width_p-1:0] shadow_d [num_cnt_lp];
  logic [num_cnt_lp-1:0]  inc;
  logic                   reason_ok;
  logic                   snap_fire;

  logic                   rd_v_q, rd_v_d;
  logic                   rd_err_q, rd_err_d;
  logic [cnt_width_p-1:0] rd_data_q, rd_data_d;
  logic [cnt_width_p-1:0] rd_mux;
  logic                   rd_hit;
  logic                   rd_accept;

  assign snap_ready_o = ~rd_v_q;
  assign rd_ready_o   = ~rd_v_q | rd_yumi_i;
  assign rd_data_v_o  = rd_v_q;
  assign rd_data_o    = rd_data_q;
  assign rd_err_o     = rd_err_q;
  assign snap_fire    = snap_v_i & snap_ready_o;
  assign rd_accept    = rd_v_i & rd_ready_o;

  // Exactly one of instr / reason / unknown bumps per enabled cycle; out-of-range codes are unknown.
  always_comb begin
    inc       = '0;
    reason_ok = stall_v_i & ({1'b0, stall_reason_i} < (lg_reasons_lp + 1)'(num_reasons_p));
    for (int i = 0; i < num_reasons_p; i++) begin
      inc[i] = en_i & ~instret_i & reason_ok & (stall_reason_i == lg_reasons_lp'(i));
    end
    inc[unk_idx_lp]   = en_i & ~instret_i & ~reason_ok;
    inc[instr_idx_lp] = en_i & instret_i;
    inc[cycle_idx_lp] = en_i;
  end

  // Shadow captures post-increment values, so a clearing snapshot loses no cycle.
  always_comb begin
    for (int i = 0; i < num_cnt_lp; i++) begin
      live_d[i]   = sat_inc(live_q[i], inc[i]);
      shadow_d[i] = snap_fire ? live_d[i] : shadow_q[i];
      if (snap_fire && snap_clear_i) begin
        live_d[i] = '0;
      end
    end
  end

  always_comb begin
    rd_hit = 1'b0;
    rd_mux = '0;
    for (int i = 0; i < num_cnt_lp; i++) begin
      if (rd_addr_i == addr_width_lp'(i)) begin
        rd_hit = 1'b1;
        rd_mux = shadow_q[i];
      end
    end
    rd_v_d    = rd_v_q;
    rd_err_d  = rd_err_q;
    rd_data_d = rd_data_q;
    if (rd_accept) begin
      rd_v_d    = 1'b1;
      rd_err_d  = ~rd_hit;
      rd_data_d = rd_mux;
    end else if (rd_yumi_i) begin
      rd_v_d   = 1'b0;
      rd_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_cnt_lp; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      rd_v_q    <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < num_cnt_lp; i++) begin
        live_q[i]   <= live_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      rd_v_q    <= rd_v_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_bp_stall_hist_counters.sv
// Directed bench: a 32-bit and a 4-bit counter instance share all stimulus;
// expected values are hand-computed from the stimulus sequence.
module tb_bp_stall_hist_counters;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, instret = 1'b0, stall_v = 1'b0;
  logic [4:0] reason = '0;
  logic       snap_v = 1'b0, snap_clear = 1'b0;
  logic       rd_v = 1'b0, rd_yumi = 1'b0;
  logic [5:0] rd_addr = '0;

  logic        snap_ready, rd_ready, rd_data_v, rd_err;
  logic [31:0] rd_data;
  logic        snap_ready4, rd_ready4, rd_data_v4, rd_err4;
  logic [3:0]  rd_data4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bp_stall_hist_counters #(.num_reasons_p(N), .cnt_width_p(32)) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .instret_i(instret), .stall_v_i(stall_v),
    .stall_reason_i(reason), .snap_v_i(snap_v), .snap_clear_i(snap_clear),
    .snap_ready_o(snap_ready), .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
    .rd_data_v_o(rd_data_v), .rd_data_o(rd_data), .rd_err_o(rd_err), .rd_yumi_i(rd_yumi)
  );

  bp_stall_hist_counters #(.num_reasons_p(N), .cnt_width_p(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .instret_i(instret), .stall_v_i(stall_v),
    .stall_reason_i(reason), .snap_v_i(snap_v), .snap_clear_i(snap_clear),
    .snap_ready_o(snap_ready4), .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready4),
    .rd_data_v_o(rd_data_v4), .rd_data_o(rd_data4), .rd_err_o(rd_err4), .rd_yumi_i(rd_yumi)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d", tag, got, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; instret = 1'b0; stall_v = 1'b0; reason = '0;
  endtask

  task automatic snap(input logic clr);
    snap_v = 1'b1; snap_clear = clr;
    cyc();
    snap_v = 1'b0; snap_clear = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int addr, input int e32, input int e4);
    rd_v = 1'b1; rd_addr = 6'(addr);
    cyc();
    rd_v = 1'b0;
    check_vec({tag, "_vld"}, {31'b0, rd_data_v}, 32'd1);
    check_vec(tag, rd_data, 32'(e32));
    check_vec({tag, "_w4"}, {28'b0, rd_data4}, 32'(e4));
    check_vec({tag, "_err"}, {31'b0, rd_err}, 32'd0);
    rd_yumi = 1'b1;
    cyc();
    rd_yumi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check_vec("rst_rd_vld", {31'b0, rd_data_v}, 32'd0);
    check_vec("rst_rd_data", rd_data, 32'd0);
    check_vec("rst_rd_err", {31'b0, rd_err}, 32'd0);
    check_vec("rst_snap_rdy", {31'b0, snap_ready}, 32'd1);
    check_vec("rst_rd_rdy", {31'b0, rd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // 4 retire, 5 stall on reason 3, 1 idle cycle
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; instret = (i < 4); stall_v = (i >= 4 && i < 9); reason = 5'd3;
      cyc();
    end
    idle();
    snap(1'b0);
    rd_chk("t1_r3", 3, 5, 5);
    rd_chk("t1_unk", N, 1, 1);
    rd_chk("t1_instr", N + 1, 4, 4);
    rd_chk("t1_cycle", N + 2, 10, 10);
    rd_chk("t1_r0", 0, 0, 0);
    rd_chk("t1_r31", 31, 0, 0);

    // Clearing snapshot on a reason-7 cycle with a coincident read of the old shadow
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; stall_v = 1'b1; reason = 5'd7;
      cyc();
    end
    snap_v = 1'b1; snap_clear = 1'b1; rd_v = 1'b1; rd_addr = 6'd7;
    cyc();
    snap_v = 1'b0; snap_clear = 1'b0; rd_v = 1'b0;
    idle();
    check_vec("t2_coinc_vld", {31'b0, rd_data_v}, 32'd1);
    check_vec("t2_coinc_old", rd_data, 32'd0);
    rd_yumi = 1'b1; cyc(); rd_yumi = 1'b0;
    rd_chk("t2_r7", 7, 4, 4);
    rd_chk("t2_cycle", N + 2, 14, 14);
    rd_chk("t2_instr", N + 1, 4, 4);
    rd_chk("t2_r3", 3, 5, 5);
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; stall_v = 1'b1; reason = 5'd7;
      cyc();
    end
    idle();
    snap(1'b0);
    rd_chk("t2b_r7", 7, 2, 2);
    rd_chk("t2b_cycle", N + 2, 2, 2);
    rd_chk("t2b_r3", 3, 0, 0);
    rd_chk("t2b_instr", N + 1, 0, 0);

    // Disabled: toggling inputs must not move any live counter
    for (int i = 0; i < 20; i++) begin
      en = 1'b0; instret = i[0]; stall_v = i[1]; reason = 5'(i);
      cyc();
    end
    idle();
    snap(1'b0);
    rd_chk("t3_r7", 7, 2, 2);
    rd_chk("t3_cycle", N + 2, 2, 2);
    rd_chk("t3_unk", N, 0, 0);
    rd_chk("t3_instr", N + 1, 0, 0);

    // Saturation in the 4-bit instance; other counters continue
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en = 1'b1; stall_v = 1'b1; reason = 5'd0;
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; instret = 1'b1; stall_v = 1'b0;
      cyc();
    end
    idle();
    snap(1'b0);
    rd_chk("t4_r0", 0, 20, 15);
    rd_chk("t4_cycle", N + 2, 25, 15);
    rd_chk("t4_instr", N + 1, 5, 5);

    // Out-of-range address
    rd_v = 1'b1; rd_addr = 6'(N + 5);
    cyc();
    rd_v = 1'b0;
    check_vec("t5_err_vld", {31'b0, rd_data_v}, 32'd1);
    check_vec("t5_err", {31'b0, rd_err}, 32'd1);
    check_vec("t5_err_data", rd_data, 32'd0);
    check_vec("t5_err_w4", {31'b0, rd_err4}, 32'd1);
    rd_yumi = 1'b1; cyc(); rd_yumi = 1'b0;
    check_vec("t5_err_drop", {31'b0, rd_data_v}, 32'd0);

    // Held response blocks reads and snapshots (a clearing snapshot is attempted meanwhile)
    rd_v = 1'b1; rd_addr = 6'(N + 2);
    cyc();
    rd_v = 1'b0;
    en = 1'b1; instret = 1'b1; snap_v = 1'b1; snap_clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_vec("t5_hold_vld", {31'b0, rd_data_v}, 32'd1);
      check_vec("t5_hold_rdy", {31'b0, rd_ready}, 32'd0);
      check_vec("t5_hold_snap_rdy", {31'b0, snap_ready}, 32'd0);
      check_vec("t5_hold_data", rd_data, 32'd25);
    end
    idle();
    snap_v = 1'b0; snap_clear = 1'b0;
    rd_yumi = 1'b1; rd_v = 1'b1; rd_addr = 6'(N + 1);
    #1;
    check_vec("t5_b2b_rdy", {31'b0, rd_ready}, 32'd1);
    cyc();
    rd_yumi = 1'b0; rd_v = 1'b0;
    check_vec("t5_b2b_vld", {31'b0, rd_data_v}, 32'd1);
    check_vec("t5_b2b_data", rd_data, 32'd5);
    rd_yumi = 1'b1; cyc(); rd_yumi = 1'b0;
    check_vec("t5_b2b_drop", {31'b0, rd_data_v}, 32'd0);
    snap(1'b0);
    rd_chk("t5_instr", N + 1, 8, 8);
    rd_chk("t5_cycle", N + 2, 28, 15);

    // Asynchronous reset drops a pending response
    rd_v = 1'b1; rd_addr = 6'(N + 2);
    cyc();
    rd_v = 1'b0;
    check_vec("t6_pre_vld", {31'b0, rd_data_v}, 32'd1);
    check_vec("t6_pre_data", rd_data, 32'd28);
    #2 rst = 1'b1;
    #1;
    check_vec("t6_async_vld", {31'b0, rd_data_v}, 32'd0);
    check_vec("t6_async_data", rd_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    check_vec("t6_snap_rdy", {31'b0, snap_ready}, 32'd1);
    rd_chk("t6_cycle", N + 2, 0, 0);
    rd_chk("t6_instr", N + 1, 0, 0);
    rd_chk("t6_r0", 0, 0, 0);
    snap(1'b0);
    rd_chk("t6_live_cycle", N + 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
